dla_pe_result_drain: RTL and testbench

//  Receiving end of the PE-array result path. Result words from the PE array arrive as

---
 rtl/dla_pe_array_pkg.sv | 18 +
 rtl/dla_pe_result_fifo.sv | 53 +++++
 rtl/dla_pe_result_drain.sv | 111 +++++++++++
 tb/tb_dla_pe_result_drain.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dla_pe_array_pkg.sv
// Shared PE-array architecture description and result-word types.
package dla_pe_array_pkg;

  typedef struct packed {
    int unsigned num_features;
    int unsigned num_results_per_cycle;
  } pe_array_arch_t;

  localparam pe_array_arch_t DEFAULT_ARCH = '{num_features: 4, num_results_per_cycle: 2};
  localparam int unsigned    RESULT_WIDTH = 8;

  localparam int unsigned DEF_NF   = DEFAULT_ARCH.num_features;
  localparam int unsigned DEF_NRPC = DEFAULT_ARCH.num_results_per_cycle;

  typedef logic [DEF_NF-1:0][RESULT_WIDTH-1:0] result_slice_t;
  typedef result_slice_t [DEF_NRPC-1:0]        result_word_t;

endpackage

// File: rtl/dla_pe_result_fifo.sv
// Result-word FIFO with wrap-bit pointers and a combinational head.
module dla_pe_result_fifo
  import dla_pe_array_pkg::*;
#(
  parameter type         word_t = result_word_t,
  parameter int unsigned DEPTH  = 4
) (
  input  logic  clk,
  input  logic  sclrn_i,
  input  logic  push_i,
  input  word_t wdata_i,
  input  logic  pop_i,
  output word_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  word_t            mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!sclrn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dla_pe_result_drain.sv
// PE-array result drain: FIFO capture, slice serializer, flush credits.
// Optional statistics counters enabled by DLA_PE_RESULT_DRAIN_STATS_EN.
module dla_pe_result_drain
  import dla_pe_array_pkg::*;
#(
  parameter pe_array_arch_t ARCH       = DEFAULT_ARCH,
  parameter int unsigned    FIFO_DEPTH = 4,
  localparam int            NF         = int'(ARCH.num_features),
  localparam int            NRPC       = int'(ARCH.num_results_per_cycle)
) (
  input  logic                                        clk,
  input  logic                                        i_sclrn,
  input  logic                                        i_result_valid,
  input  logic [NRPC-1:0][NF-1:0][RESULT_WIDTH-1:0]   i_result_data,
  input  logic                                        i_flush_issue,
  output logic                                        o_flush_credit_ok,
  output logic                                        o_valid,
  output logic [NF-1:0][RESULT_WIDTH-1:0]             o_data,
  output logic                                        o_last,
  input  logic                                        i_ready,
  output logic                                        o_overflow,
  output logic [31:0]                                 o_stat_words,
  output logic [31:0]                                 o_stat_stalls
);

  typedef logic [NF-1:0][RESULT_WIDTH-1:0] slice_t;
  typedef slice_t [NRPC-1:0]               word_t;

  localparam int                 SIDX_W   = (NRPC > 1) ? $clog2(NRPC) : 1;
  localparam int                 CRED_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [SIDX_W-1:0]  LAST_IDX = SIDX_W'(NRPC - 1);
  localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(FIFO_DEPTH);

  word_t              head;
  logic               full, empty;
  logic               handshake, pop, push;
  logic [SIDX_W-1:0]  slice_idx_q, slice_idx_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic               overflow_q, overflow_d;

  dla_pe_result_fifo #(.word_t(word_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .sclrn_i (i_sclrn),
    .push_i  (push),
    .wdata_i (i_result_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign o_valid           = !empty;
  assign o_last            = (slice_idx_q == LAST_IDX);
  assign o_data            = head[slice_idx_q];
  assign o_overflow        = overflow_q;
  assign o_flush_credit_ok = (credits_q != '0);

  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign handshake = o_valid && i_ready;
  assign pop       = handshake && o_last;
  assign push      = i_result_valid && (!full || pop);

  always_comb begin
    slice_idx_d = slice_idx_q;
    overflow_d  = overflow_q || (i_result_valid && full && !pop);
    credits_d   = credits_q;
    if (handshake) slice_idx_d = o_last ? '0 : slice_idx_q + SIDX_W'(1);
    if (i_flush_issue && !pop) begin
      if (credits_q != '0) credits_d = credits_q - CRED_W'(1);
    end else if (pop && !i_flush_issue) begin
      if (credits_q != CRED_MAX) credits_d = credits_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_sclrn) begin
      slice_idx_q <= '0;
      credits_q   <= CRED_MAX;
      overflow_q  <= 1'b0;
    end else begin
      slice_idx_q <= slice_idx_d;
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef DLA_PE_RESULT_DRAIN_STATS_EN
  logic [31:0] stat_words_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (!i_sclrn) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (pop)                  stat_words_q  <= stat_words_q + 32'd1;
      if (o_valid && !i_ready)  stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign o_stat_words  = stat_words_q;
  assign o_stat_stalls = stat_stalls_q;
`else
  assign o_stat_words  = '0;
  assign o_stat_stalls = '0;
`endif

  // A flush issued with no credit means the sequencer ignored o_flush_credit_ok.
  a_no_issue_without_credit : assert property (@(posedge clk) disable iff (!i_sclrn)
    !(i_flush_issue && (credits_q == '0)));

endmodule

// File: tb/tb_dla_pe_result_drain.sv
// Self-checking bench for dla_pe_result_drain against a queue-based reference model.
module tb_dla_pe_result_drain;
  import dla_pe_array_pkg::*;

  localparam int DEPTH = 4;
  localparam int NRPC  = int'(DEF_NRPC);

  logic          clk = 1'b0;
  logic          i_sclrn = 1'b0;
  logic          i_result_valid = 1'b0;
  result_word_t  i_result_data = '0;
  logic          i_flush_issue = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_flush_credit_ok, o_valid, o_last, o_overflow;
  result_slice_t o_data;
  logic [31:0]   o_stat_words, o_stat_stalls;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  result_word_t m_q[$];
  int           m_idx, m_credits, m_words, m_stalls, m_outstanding;
  bit           m_ovf, track_outstanding;

  always #5 clk = ~clk;

  dla_pe_result_drain #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .i_sclrn           (i_sclrn),
    .i_result_valid    (i_result_valid),
    .i_result_data     (i_result_data),
    .i_flush_issue     (i_flush_issue),
    .o_flush_credit_ok (o_flush_credit_ok),
    .o_valid           (o_valid),
    .o_data            (o_data),
    .o_last            (o_last),
    .i_ready           (i_ready),
    .o_overflow        (o_overflow),
    .o_stat_words      (o_stat_words),
    .o_stat_stalls     (o_stat_stalls)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic result_word_t rand_word();
    result_word_t w;
    w = {$urandom(), $urandom()};
    return w;
  endfunction

  // Spec-level behaviour of one clock edge, applied to the model.
  task automatic model_edge();
    bit hs, last, pop;
    if (!i_sclrn) begin
      m_q.delete();
      m_idx = 0; m_credits = DEPTH; m_ovf = 0; m_words = 0; m_stalls = 0; m_outstanding = 0;
      return;
    end
    hs   = (m_q.size() > 0) && i_ready;
    last = (m_idx == NRPC - 1);
    pop  = hs && last;
    if ((m_q.size() > 0) && !i_ready) m_stalls++;
    if (hs) begin
      if (last) begin
        void'(m_q.pop_front());
        m_idx = 0;
        m_words++;
      end else m_idx++;
    end
    if (i_result_valid) begin
      if (m_q.size() < DEPTH) m_q.push_back(i_result_data);
      else m_ovf = 1;
      if (m_outstanding > 0) m_outstanding--;
    end
    if (i_flush_issue) m_outstanding++;
    if (i_flush_issue && !pop) begin
      if (m_credits > 0) m_credits--;
    end else if (pop && !i_flush_issue) begin
      if (m_credits < DEPTH) m_credits++;
    end
  endtask

  task automatic check_all();
    int exp_words, exp_stalls;
`ifdef DLA_PE_RESULT_DRAIN_STATS_EN
    exp_words = m_words; exp_stalls = m_stalls;
`else
    exp_words = 0; exp_stalls = 0;
`endif
    check("valid", 64'(o_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("data", 64'(o_data), 64'(m_q[0][m_idx]));
      check("last", 64'(o_last), 64'(m_idx == NRPC - 1));
    end
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    check("credit_ok", 64'(o_flush_credit_ok), 64'(m_credits > 0));
    if (track_outstanding)
      check("credit_balance", 64'(o_flush_credit_ok),
            64'((DEPTH - m_q.size() - m_outstanding) > 0));
    check("stat_words", 64'(o_stat_words), 64'(exp_words));
    check("stat_stalls", 64'(o_stat_stalls), 64'(exp_stalls));
  endtask

  task automatic step(input bit rst_n, input bit vld, input result_word_t d,
                      input bit issue, input bit rdy);
    i_sclrn = rst_n; i_result_valid = vld; i_result_data = d;
    i_flush_issue = issue; i_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    result_word_t w;
    track_outstanding = 0;
    #1;

    // Reset state
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // T1: basic serialize with credit return
    w[0] = 32'h04030201;
    w[1] = 32'h14131211;
    step(1, 0, '0, 1, 1);
    step(1, 1, w, 0, 1);
    check("t1_slice0", 64'(o_data), 64'h04030201);
    check("t1_last0", 64'(o_last), 64'd0);
    step(1, 0, '0, 0, 1);
    check("t1_slice1", 64'(o_data), 64'h14131211);
    check("t1_last1", 64'(o_last), 64'd1);
    step(1, 0, '0, 0, 1);
    check("t1_empty", 64'(o_valid), 64'd0);
    step(1, 0, '0, 0, 1);

    // T2: full with backpressure, then overflow
    for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 0);
    check("t2_no_credit", 64'(o_flush_credit_ok), 64'd0);
    for (int i = 0; i < 4; i++) step(1, 1, rand_word(), 0, 0);
    step(1, 0, '0, 0, 0);
    check("t2_no_overflow", 64'(o_overflow), 64'd0);
    step(1, 1, rand_word(), 0, 0);
    check("t2_overflow", 64'(o_overflow), 64'd1);

    // T3: full FIFO, push coinciding with last-slice pop
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, rand_word(), 0, 0);
    step(1, 0, '0, 0, 1);
    step(1, 1, rand_word(), 0, 1);
    check("t3_no_overflow", 64'(o_overflow), 64'd0);
    for (int i = 0; i < 10; i++) step(1, 0, '0, 0, 1);
    check("t3_drained", 64'(o_valid), 64'd0);

    // T4: reset mid-drain
    step(1, 0, '0, 1, 0);
    step(1, 1, rand_word(), 0, 0);
    step(1, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    check("t4_valid", 64'(o_valid), 64'd0);
    check("t4_credit_ok", 64'(o_flush_credit_ok), 64'd1);
    step(1, 1, rand_word(), 0, 0);
    check("t4_restart_slice0", 64'(o_last), 64'd0);

    // T5: flush issue coinciding with a pop leaves credits unchanged
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0);
    step(1, 1, rand_word(), 0, 1);
    step(1, 0, '0, 0, 1);
    step(1, 0, '0, 1, 1);
    check("t5_balanced", 64'(o_flush_credit_ok), 64'd1);
    step(1, 0, '0, 1, 0);
    check("t5_exhausted", 64'(o_flush_credit_ok), 64'd0);

    // T5: random credit-balanced traffic
    step(0, 0, '0, 0, 0);
    track_outstanding = 1;
    for (int i = 0; i < 10000; i++) begin
      bit iss, vld;
      iss = (m_credits > 0) && ($urandom_range(0, 3) == 0);
      vld = (m_outstanding > 0) && ($urandom_range(0, 2) == 0);
      step(1, vld, rand_word(), iss, 1'($urandom_range(0, 1)));
    end
    track_outstanding = 0;

    // T6: statistics, 3 words and 7 stall cycles
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, rand_word(), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, '0, 0, 1);
`ifdef DLA_PE_RESULT_DRAIN_STATS_EN
    check("t6_words", 64'(o_stat_words), 64'd3);
    check("t6_stalls", 64'(o_stat_stalls), 64'd7);
`else
    check("t6_words_off", 64'(o_stat_words), 64'd0);
    check("t6_stalls_off", 64'(o_stat_stalls), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
